// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared constants and FSM state encoding for the UART frame arbiter
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam logic [7:0] C_HEADER_BYTE = 8'hA5;
    localparam logic [7:0] C_CH_ID0      = 8'h00;
    localparam logic [7:0] C_CH_ID1      = 8'h01;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        GRANT   = 4'd1,
        HDR     = 4'd2,
        ID      = 4'd3,
        LEN_H   = 4'd4,
        LEN_L   = 4'd5,
        FETCH   = 4'd6,
        PAY     = 4'd7,
        CSUM    = 4'd8,
        WAIT_TX = 4'd9,
        DONE    = 4'd10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
//------------------------------------------------------------------------------
// uart_rr_arbiter : two-way round-robin selector, requester 0 favoured after reset
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_served
);

    // prio_q names the requester that wins the next tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant  = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
        if (advance) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign last_served = ~prio_q;

endmodule

`default_nettype wire

// File: rtl/uart_frame_arbiter.sv
//------------------------------------------------------------------------------
// uart_frame_arbiter : frames payloads of two requesters onto one byte transmitter
// Optional checksum byte enabled by macro UART_FRAME_CHECKSUM_EN.   Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_arbiter
    import uart_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = C_HEADER_BYTE,
    parameter logic [9:0] MAX_LEN     = 10'd405
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [1:0] in_req,
    input  logic [9:0] in_len0,
    input  logic [9:0] in_len1,
    output logic [1:0] out_grant,
    output logic       out_rd_en,
    input  logic [7:0] in_rd_data,
    output logic       out_tx_en,
    output logic [7:0] out_tx_data,
    input  logic       in_tx_done,
    output logic       out_busy,
    output logic       out_frame_done
);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam state_t C_LAST_STATE = CSUM;
`else
    localparam state_t C_LAST_STATE = DONE;
`endif

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [1:0] grant_q, grant_d;
    logic [9:0] len_q, len_d;
    logic [9:0] cnt_q, cnt_d;
    logic       tx_done_q;
    logic       tx_rise;
    logic [1:0] arb_grant;
    logic       arb_last;
    logic       advance;
    logic [9:0] req_len;
    logic [7:0] ch_id;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    uart_rr_arbiter u_rr (
        .clk         (in_clk),
        .rst         (in_rst),
        .req         (in_req),
        .advance     (advance),
        .grant       (arb_grant),
        .last_served (arb_last)
    );

    assign tx_rise   = in_tx_done & ~tx_done_q;
    assign req_len   = arb_grant[1] ? in_len1 : in_len0;
    // Pointer has already advanced past this frame's owner once HDR is reached
    assign ch_id     = arb_last ? C_CH_ID1 : C_CH_ID0;
    assign out_grant = grant_q;
    assign out_busy  = (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        grant_d        = grant_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        advance        = 1'b0;
        out_rd_en      = 1'b0;
        out_tx_en      = 1'b0;
        out_tx_data    = 8'h00;
        out_frame_done = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (|in_req) state_d = GRANT;
            end
            GRANT: begin
                if (|arb_grant) begin
                    grant_d = arb_grant;
                    advance = 1'b1;
                    len_d   = (req_len > MAX_LEN) ? MAX_LEN : req_len;
                    cnt_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = HDR;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                out_tx_en   = 1'b1;
                out_tx_data = HEADER_BYTE;
                ret_d       = ID;
                state_d     = WAIT_TX;
            end
            ID: begin
                out_tx_en   = 1'b1;
                out_tx_data = ch_id;
                ret_d       = LEN_H;
                state_d     = WAIT_TX;
            end
            LEN_H: begin
                out_tx_en   = 1'b1;
                out_tx_data = {6'd0, len_q[9:8]};
                ret_d       = LEN_L;
                state_d     = WAIT_TX;
            end
            LEN_L: begin
                out_tx_en   = 1'b1;
                out_tx_data = len_q[7:0];
                ret_d       = (len_q == '0) ? C_LAST_STATE : FETCH;
                state_d     = WAIT_TX;
            end
            FETCH: begin
                out_rd_en = 1'b1;
                state_d   = PAY;
            end
            PAY: begin
                out_tx_en   = 1'b1;
                out_tx_data = in_rd_data;
                cnt_d       = cnt_q + 10'd1;
                ret_d       = (cnt_q + 10'd1 == len_q) ? C_LAST_STATE : FETCH;
                state_d     = WAIT_TX;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CSUM: begin
                out_tx_en   = 1'b1;
                out_tx_data = sum_q;
                ret_d       = DONE;
                state_d     = WAIT_TX;
            end
`endif
            WAIT_TX: begin
                if (tx_rise) begin
                    state_d = ret_q;
                    if (ret_q == DONE) grant_d = '0;
                end
            end
            DONE: begin
                out_frame_done = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_FRAME_CHECKSUM_EN
        // Header and the checksum byte itself are excluded from the sum
        if (out_tx_en && (state_q != HDR) && (state_q != CSUM)) begin
            sum_d = sum_q + out_tx_data;
        end
`endif
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= IDLE;
            ret_q     <= IDLE;
            grant_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            grant_q   <= grant_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tx_done_q <= in_tx_done;
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_frame_arbiter : self-checking bench with transmitter/requester models
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_frame_arbiter;

    localparam int MAXL = 405;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [1:0] in_req  = '0;
    logic [9:0] in_len0 = '0;
    logic [9:0] in_len1 = '0;
    logic [7:0] in_rd_data;
    logic       in_tx_done;
    logic [1:0] out_grant;
    logic       out_rd_en;
    logic       out_tx_en;
    logic [7:0] out_tx_data;
    logic       out_busy;
    logic       out_frame_done;

    always #5 clk = ~clk;

    uart_frame_arbiter dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_req         (in_req),
        .in_len0        (in_len0),
        .in_len1        (in_len1),
        .out_grant      (out_grant),
        .out_rd_en      (out_rd_en),
        .in_rd_data     (in_rd_data),
        .out_tx_en      (out_tx_en),
        .out_tx_data    (out_tx_data),
        .in_tx_done     (in_tx_done),
        .out_busy       (out_busy),
        .out_frame_done (out_frame_done)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] fix_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] gr_q[$];
    int         fd_cnt   = 0;
    int         rd_cnt   = 0;
    int         rd_off   = 0;
    int         exp_rd   = 0;
    int         pend     = 0;
    int         hold_cyc = 0;
    logic [1:0] prev_grant = '0;

    // Output monitor: transmitted bytes, frame-done pulses, new grants
    initial forever begin
        @(negedge clk);
        if (out_tx_en === 1'b1) begin
            tx_q.push_back(out_tx_data);
            pend++;
        end
        if (out_frame_done === 1'b1) fd_cnt++;
        if (out_grant !== prev_grant && out_grant !== 2'b00) gr_q.push_back(out_grant);
        prev_grant = out_grant;
    end

    // Requester model: byte appears one cycle after the read strobe
    initial begin
        in_rd_data = '0;
        forever begin
            @(negedge clk);
            if (out_rd_en === 1'b1) begin
                @(posedge clk);
                #1;
                if (fix_q.size() > 0) in_rd_data = fix_q.pop_front();
                else                  in_rd_data = 8'($urandom);
                rd_q.push_back(in_rd_data);
                rd_cnt++;
            end
        end
    end

    // Transmitter model: one done pulse (of configurable length) per started byte
    initial begin
        in_tx_done = 1'b0;
        forever begin
            int h;
            wait (pend > 0);
            pend--;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            h = (hold_cyc > 0) ? hold_cyc : int'($urandom_range(1, 3));
            in_tx_done = 1'b1;
            repeat (h) @(negedge clk);
            in_tx_done = 1'b0;
            @(negedge clk);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        tx_q.delete();
        rd_q.delete();
        exp_q.delete();
        gr_q.delete();
        rd_cnt = 0;
        rd_off = 0;
        exp_rd = 0;
        fd_cnt = 0;
    endtask

    // Expected frame from the framing rules; payload is what the requester model supplied
    task automatic model_frame(input int ch, input int len);
        int         l = (len > MAXL) ? MAXL : len;
        logic [7:0] s;
        logic [7:0] b[$];
        b = {8'hA5, 8'(ch), 8'(l / 256), 8'(l % 256)};
        for (int i = 0; i < l; i++) begin
            if (rd_off < rd_q.size()) b.push_back(rd_q[rd_off]);
            else                      b.push_back(8'hxx);
            rd_off++;
        end
        s = '0;
        for (int i = 1; i < b.size(); i++) s = s + b[i];
`ifdef UART_FRAME_CHECKSUM_EN
        b.push_back(s);
`endif
        foreach (b[i]) exp_q.push_back(b[i]);
        exp_rd += l;
    endtask

    task automatic check_stream(input string tag);
        int b0 = bad;
        chk({tag, "_count"}, tx_q.size(), exp_q.size());
        chk({tag, "_reads"}, rd_cnt, exp_rd);
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, exp_q[i]});
            if (bad != b0) break;
        end
    endtask

    // Raise a request, and once the frame is owned optionally drop it and scramble lengths
    task automatic start_frame(input logic [1:0] req, input int l0, input int l1, input bit keep);
        int c = 0;
        in_req  = req;
        in_len0 = 10'(l0);
        in_len1 = 10'(l1);
        while (out_busy !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        if (out_busy !== 1'b1) chk("busy_timeout", out_busy, 1);
        @(negedge clk);
        if (!keep) begin
            in_req  = '0;
            in_len0 = 10'($urandom);
            in_len1 = 10'($urandom);
        end
    endtask

    task automatic wait_frames(input int n);
        int seen = 0;
        int c    = 0;
        while (seen < n && c < 40000) begin
            @(negedge clk);
            c++;
            if (out_frame_done === 1'b1) seen++;
        end
        if (seen < n) chk("frame_timeout", seen, n);
    endtask

    initial begin
        logic [7:0] v[$];
        int         c;
        int         bh;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  out_busy, 0);
        chk("rst_grant", out_grant, 0);
        chk("rst_txen",  out_tx_en, 0);
        chk("rst_rden",  out_rd_en, 0);
        chk("rst_txdat", out_tx_data, 0);
        chk("rst_fdone", out_frame_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three-byte frame on requester 0 with known payload
        clr();
        fix_q = {8'h11, 8'h22, 8'h33};
        start_frame(2'b01, 3, 0, 0);
        wait_frames(1);
        repeat (2) @(negedge clk);
`ifdef UART_FRAME_CHECKSUM_EN
        v = {8'hA5, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
`else
        v = {8'hA5, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`endif
        exp_q = v;
        exp_rd = 3;
        check_stream("f3");
        chk("f3_fdone", fd_cnt, 1);
        chk("f3_grant", (gr_q.size() > 0) ? 32'(gr_q[0]) : 32'hF, 2'b01);

        // Zero-length frame
        clr();
        start_frame(2'b01, 0, 0, 0);
        wait_frames(1);
        repeat (2) @(negedge clk);
        model_frame(0, 0);
        check_stream("len0");

        // Oversized length is clipped
        clr();
        hold_cyc = 1;
        start_frame(2'b10, 0, 600, 0);
        wait_frames(1);
        repeat (2) @(negedge clk);
        model_frame(1, 600);
        check_stream("clip");
        chk("clip_grant", (gr_q.size() > 0) ? 32'(gr_q[0]) : 32'hF, 2'b10);
        hold_cyc = 0;

        // Random single-requester frames
        for (int k = 0; k < 5; k++) begin
            int ch  = int'($urandom_range(0, 1));
            int len = int'($urandom_range(0, 24));
            clr();
            start_frame((ch == 1) ? 2'b10 : 2'b01, len, len, 0);
            wait_frames(1);
            repeat (2) @(negedge clk);
            model_frame(ch, len);
            check_stream($sformatf("rnd%0d", k));
        end

        // Done level held high advances exactly one byte
        clr();
        hold_cyc = 50;
        start_frame(2'b01, 3, 0, 0);
        c = 0;
        while (in_tx_done !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        hold_cyc = 0;
        repeat (45) @(negedge clk);
        chk("hold_bytes", tx_q.size(), 2);
        wait_frames(1);
        repeat (2) @(negedge clk);
        model_frame(0, 3);
        check_stream("hold");

        // Reset in the middle of a frame
        clr();
        start_frame(2'b01, 10, 0, 0);
        c = 0;
        while (tx_q.size() < 6 && c < 500) begin @(negedge clk); c++; end
        chk("mid_reached", (tx_q.size() >= 6) ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_busy",  out_busy, 0);
        chk("mid_grant", out_grant, 0);
        chk("mid_txen",  out_tx_en, 0);
        chk("mid_rden",  out_rd_en, 0);
        chk("mid_txdat", out_tx_data, 0);
        chk("mid_fdone", out_frame_done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bh = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_busy !== 1'b0) bh++;
        end
        chk("no_resume", bh, 0);
        pend = 0;
        clr();

        // Both requesting across three frames; requester 0 first after reset
        start_frame(2'b11, 2, 3, 1);
        wait_frames(3);
        in_req = '0;
        repeat (3) @(negedge clk);
        chk("rr_frames", fd_cnt, 3);
        chk("rr_ngrants", gr_q.size(), 3);
        chk("rr_g0", (gr_q.size() > 0) ? 32'(gr_q[0]) : 32'hF, 2'b01);
        chk("rr_g1", (gr_q.size() > 1) ? 32'(gr_q[1]) : 32'hF, 2'b10);
        chk("rr_g2", (gr_q.size() > 2) ? 32'(gr_q[2]) : 32'hF, 2'b01);
        model_frame(0, 2);
        model_frame(1, 3);
        model_frame(0, 2);
        check_stream("rr");
        bh = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_busy !== 1'b0) bh++;
        end
        chk("rr_idle", bh, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hA5, first byte of every frame.
REQ-002 SHALL have parameter MAX_LEN, default 10'd405, maximum payload bytes per frame.
REQ-003 SHALL have port in_clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port in_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_req, input, 2, per-requester frame request level (bit0 = waveform channel, bit1 = status channel).
REQ-006 SHALL have ports in_len0 and in_len1, input, 10 each, payload length of requester 0/1, sampled at grant.
REQ-007 SHALL have port out_grant, output, 2, one-hot owner of the transmitter for the whole frame.
REQ-008 SHALL have port out_rd_en, output, 1, one-cycle payload byte read strobe to the granted requester.
REQ-009 SHALL have port in_rd_data, input, 8, granted requester's byte, valid exactly one cycle after out_rd_en.
REQ-010 SHALL have ports out_tx_en (1-cycle start pulse) and out_tx_data (8) toward the byte transmitter.
REQ-011 SHALL have port in_tx_done, input, 1, transmitter done level; its rising edge marks one byte finished.
REQ-012 SHALL have ports out_busy (1) and out_frame_done (1-cycle pulse after the last byte's done edge).

Function
REQ-013 SHALL use states IDLE, GRANT, HDR, ID, LEN_H, LEN_L, FETCH, PAY, CSUM, WAIT_TX, DONE.
REQ-014 SHALL leave IDLE when any in_req bit is high; GRANT selects one requester, latches its length and sets out_grant one-hot.
REQ-015 SHALL arbitrate round-robin: when both request, grant the requester not served last; after reset requester 0 has priority.
REQ-016 SHALL clip latched length to MAX_LEN; length 0 sends header, ID, length (and checksum) with no payload.
REQ-017 SHALL emit bytes in order HEADER_BYTE, channel ID (8'h00/8'h01), length[9:8] zero-extended, length[7:0], payload, checksum.
REQ-018 SHALL present out_tx_data together with a one-cycle out_tx_en pulse, then enter WAIT_TX until the in_tx_done rising edge.
REQ-019 SHALL, per payload byte, pulse out_rd_en in FETCH and launch in_rd_data in PAY on the following cycle; exactly latched-length reads per frame.
REQ-020 SHALL detect the in_tx_done rising edge with a one-cycle-delayed register; a level held high counts once.
REQ-021 SHALL ignore in_req changes and in_len changes while a frame is in progress; a dropped request does not abort the frame.
REQ-022 SHALL pulse out_frame_done one cycle in DONE, clear out_grant, and return to IDLE; a pending request is granted on the next cycle.
REQ-023 SHALL hold out_busy high from GRANT through DONE inclusive.
REQ-024 SHALL count payload bytes in a 10-bit counter that never wraps (bounded by MAX_LEN).

Reset
REQ-025 SHALL, on in_rst high at any time including mid-frame, force state IDLE, out_grant=0, out_rd_en=0, out_tx_en=0, out_tx_data=0, out_busy=0, out_frame_done=0, counter and checksum 0, round-robin pointer to requester 0.
REQ-026 SHALL not resume an interrupted frame after reset release.

Configuration
REQ-027 SHALL implement checksum under macro UART_FRAME_CHECKSUM_EN: defined -> CSUM state sends 8-bit mod-256 sum of ID, LEN_H, LEN_L and payload bytes; undefined -> CSUM state and checksum register absent, DONE follows last payload/length byte.

Structure
REQ-028 SHALL take HEADER_BYTE default, channel ID constants and the state enumeration from shared package uart_pkg.
REQ-029 SHALL place round-robin selection in sub-module uart_rr_arbiter (inputs req[1:0], advance; output one-hot grant, last-served pointer).

Verification
REQ-030 SHALL cover: in_req=01, in_len0=3, payload 11,22,33 -> tx bytes A5,00,00,03,11,22,33,69 (checksum on), out_frame_done once.
REQ-031 SHALL cover: in_req=11 held for two frames -> grants 01 then 10; third frame grants 01.
REQ-032 SHALL cover: in_len1=600 -> length bytes 01,95, exactly 405 out_rd_en pulses.
REQ-033 SHALL cover: in_len0=0 -> tx A5,00,00,00,00, zero out_rd_en pulses.
REQ-034 SHALL cover: in_rst asserted after 2nd payload byte -> all outputs 0 in same cycle, IDLE; next frame starts with A5.
REQ-035 SHALL cover: in_tx_done held high 50 cycles -> exactly one byte advance; macro undefined -> frame of REQ-030 ends at 33.
